// File: rtl/qu_common_pkg.sv
// Shared decode-stage types: instruction classes, the decoded beat layout
// and the RV32I decode function used by qu_decode_stage.
package qu_common_pkg;

    localparam int QU_PC_WIDTH = 12;

    typedef logic [31:0] instr_t;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_I       = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_SYSTEM  = 4'd9,
        CLS_CSR     = 4'd10,
        CLS_FENCE   = 4'd11,
        CLS_ILLEGAL = 4'd12
    } instr_class_t;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        instr_class_t cls;
        logic [2:0]   funct3;
        logic         alt;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [31:0]  imm;
        logic [11:0]  csr;
        logic         rd_we;
        logic         illegal;
    } decoded_t;

    // Splits one instruction word into its decoded fields. Illegal words still
    // produce raw fields, but the class is forced to CLS_ILLEGAL and rd_we is
    // cleared so nothing downstream can commit them.
    function automatic decoded_t decode_instr(input instr_t instr,
                                              input logic   enable_csr,
                                              input logic   enable_fencei);
        decoded_t     d;
        logic [6:0]   opcode;
        logic [2:0]   funct3;
        logic [6:0]   funct7;
        logic [31:0]  imm_i;
        logic [31:0]  imm_s;
        logic [31:0]  imm_b;
        logic [31:0]  imm_u;
        logic [31:0]  imm_j;
        logic [31:0]  imm;
        instr_class_t cls;
        logic         legal;
        logic         writes_rd;
        logic         keep_rd;

        opcode = instr[6:0];
        funct3 = instr[14:12];
        funct7 = instr[31:25];

        imm_i = {{20{instr[31]}}, instr[31:20]};
        imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u = {instr[31:12], 12'h000};
        imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

        d         = '0;
        imm       = '0;
        cls       = CLS_ILLEGAL;
        legal     = 1'b0;
        writes_rd = 1'b0;
        keep_rd   = 1'b1;

        case (opcode)
            OP_OP: begin
                cls       = CLS_R;
                writes_rd = 1'b1;
                legal     = (funct7 == F7_ZERO) ||
                            ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OP_IMM: begin
                cls       = CLS_I;
                writes_rd = 1'b1;
                imm       = imm_i;
                case (funct3)
                    3'b001:  legal = (funct7 == F7_ZERO);
                    3'b101:  legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    default: legal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                cls       = CLS_LOAD;
                writes_rd = 1'b1;
                imm       = imm_i;
                legal     = !((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));
            end
            OP_STORE: begin
                cls     = CLS_STORE;
                keep_rd = 1'b0;
                imm     = imm_s;
                legal   = (funct3 <= 3'b010);
            end
            OP_BRANCH: begin
                cls     = CLS_BRANCH;
                keep_rd = 1'b0;
                imm     = imm_b;
                legal   = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OP_JAL: begin
                cls       = CLS_JAL;
                writes_rd = 1'b1;
                imm       = imm_j;
                legal     = 1'b1;
            end
            OP_JALR: begin
                cls       = CLS_JALR;
                writes_rd = 1'b1;
                imm       = imm_i;
                legal     = (funct3 == 3'b000);
            end
            OP_LUI: begin
                cls       = CLS_LUI;
                writes_rd = 1'b1;
                imm       = imm_u;
                legal     = 1'b1;
            end
            OP_AUIPC: begin
                cls       = CLS_AUIPC;
                writes_rd = 1'b1;
                imm       = imm_u;
                legal     = 1'b1;
            end
            OP_FENCE: begin
                cls     = CLS_FENCE;
                keep_rd = 1'b0;
                imm     = imm_i;
                legal   = (funct3 == 3'b000) || ((funct3 == 3'b001) && enable_fencei);
            end
            OP_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    cls     = CLS_SYSTEM;
                    keep_rd = 1'b0;
                    imm     = imm_i;
                    legal   = ((instr[31:20] == 12'h000) || (instr[31:20] == 12'h001)) &&
                              (instr[11:7] == 5'd0) && (instr[19:15] == 5'd0);
                end else begin
                    cls       = CLS_CSR;
                    writes_rd = 1'b1;
                    imm       = funct3[2] ? {27'd0, instr[19:15]} : imm_i;
                    legal     = (funct3 != 3'b100) && enable_csr;
                end
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        d.cls     = legal ? cls : CLS_ILLEGAL;
        d.funct3  = funct3;
        d.alt     = instr[30];
        d.rd      = keep_rd ? instr[11:7] : 5'd0;
        d.rs1     = instr[19:15];
        d.rs2     = instr[24:20];
        d.imm     = imm;
        d.csr     = instr[31:20];
        d.rd_we   = writes_rd && legal && (instr[11:7] != 5'd0);
        d.illegal = !legal;
        return d;
    endfunction

endpackage

// File: rtl/qu_skid_buffer.sv
// Two-entry valid/ready buffer: an output register plus one skid register,
// so in_ready comes straight from a flop and never from out_ready.
module qu_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic             skid_valid_q;
    logic             skid_valid_d;
    logic [WIDTH-1:0] skid_data_q;
    logic [WIDTH-1:0] skid_data_d;
    logic             in_ready_q;
    logic             in_ready_d;
    logic             accept;
    logic             out_free;

    assign accept   = in_valid & in_ready_q;
    assign out_free = !out_valid_q | out_ready;

    // Next state: the skid entry always drains ahead of new input to keep FIFO order.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_data_d = in_data;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end

        in_ready_d = !skid_valid_d;
    end

    // State registers; reset clears data too so idle outputs read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/qu_decode_stage.sv
// RV32I decode stage: decodes the incoming fetch beat combinationally and
// registers the result together with its pc through a 2-entry skid buffer.
module qu_decode_stage
    import qu_common_pkg::*;
#(
    parameter int   PC_WIDTH      = QU_PC_WIDTH,
    parameter logic ENABLE_CSR    = 1'b1,
    parameter logic ENABLE_FENCEI = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic [31:0]         in_instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [3:0]          out_class,
    output logic [2:0]          out_funct3,
    output logic                out_alt,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [31:0]         out_imm,
    output logic [11:0]         out_csr,
    output logic                out_rd_we,
    output logic                out_illegal
);

    localparam int DEC_W = $bits(decoded_t);
    localparam int BUF_W = DEC_W + PC_WIDTH;

    decoded_t         in_dec;
    decoded_t         out_dec;
    logic [BUF_W-1:0] buf_in;
    logic [BUF_W-1:0] buf_out;

    assign in_dec = decode_instr(in_instr, ENABLE_CSR, ENABLE_FENCEI);
    assign buf_in = {in_pc, in_dec};

    qu_skid_buffer #(
        .WIDTH (BUF_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (buf_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

    assign out_dec     = buf_out[DEC_W-1:0];
    assign out_pc      = buf_out[BUF_W-1 -: PC_WIDTH];
    assign out_class   = out_dec.cls;
    assign out_funct3  = out_dec.funct3;
    assign out_alt     = out_dec.alt;
    assign out_rd      = out_dec.rd;
    assign out_rs1     = out_dec.rs1;
    assign out_rs2     = out_dec.rs2;
    assign out_imm     = out_dec.imm;
    assign out_csr     = out_dec.csr;
    assign out_rd_we   = out_dec.rd_we;
    assign out_illegal = out_dec.illegal;

endmodule

// File: tb/tb_qu_decode_stage.sv
// Self-checking bench for qu_decode_stage: directed scenarios followed by a
// randomized run, with a queue-based reference model of the stage contents.
module tb_qu_decode_stage;
    import qu_common_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [11:0] in_pc;
    logic [31:0] in_instr;

    logic        f_in_ready, f_out_valid, f_alt, f_rd_we, f_illegal;
    logic [11:0] f_pc, f_csr;
    logic [3:0]  f_class;
    logic [2:0]  f_funct3;
    logic [4:0]  f_rd, f_rs1, f_rs2;
    logic [31:0] f_imm;

    logic        m_in_ready, m_out_valid, m_alt, m_rd_we, m_illegal;
    logic [11:0] m_pc, m_csr;
    logic [3:0]  m_class;
    logic [2:0]  m_funct3;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [31:0] m_imm;

    always #5 clk = ~clk;

    qu_decode_stage #(.PC_WIDTH(12), .ENABLE_CSR(1'b1), .ENABLE_FENCEI(1'b1)) dut_full (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(f_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(f_out_valid), .out_ready(out_ready),
        .out_pc(f_pc), .out_class(f_class), .out_funct3(f_funct3), .out_alt(f_alt),
        .out_rd(f_rd), .out_rs1(f_rs1), .out_rs2(f_rs2), .out_imm(f_imm), .out_csr(f_csr),
        .out_rd_we(f_rd_we), .out_illegal(f_illegal)
    );

    qu_decode_stage #(.PC_WIDTH(12), .ENABLE_CSR(1'b0), .ENABLE_FENCEI(1'b0)) dut_min (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_pc(m_pc), .out_class(m_class), .out_funct3(m_funct3), .out_alt(m_alt),
        .out_rd(m_rd), .out_rs1(m_rs1), .out_rs2(m_rs2), .out_imm(m_imm), .out_csr(m_csr),
        .out_rd_we(m_rd_we), .out_illegal(m_illegal)
    );

    typedef struct {
        logic        in_ready;
        logic        out_valid;
        logic [11:0] pc;
        logic [3:0]  cls;
        logic [2:0]  funct3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [11:0] csr;
        logic        rd_we;
        logic        illegal;
    } obs_t;

    typedef struct {
        logic [3:0]  cls;
        logic [2:0]  funct3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [11:0] csr;
        logic        rd_we;
        logic        illegal;
    } exp_t;

    typedef struct {
        logic [11:0] pc;
        logic [31:0] instr;
    } beat_t;

    beat_t       sb[$];
    logic [11:0] delivered[$];
    bit          model_ready = 1'b0;
    bit          was_reset = 1'b0;
    bit          last_accepted = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic cmp(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference decode from the instruction-set rules, using integer arithmetic for immediates.
    function automatic exp_t refDecode(input logic [31:0] w, input bit en_csr, input bit en_fencei);
        exp_t e;
        int   s, op, f3, f7, rdn;
        int   imm_i, imm_s, imm_b, imm_j;
        bit   legal, writes, no_rd;
        instr_class_t c;
        s  = $signed(w);
        op = int'(w[6:0]);
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        rdn = int'(w[11:7]);
        imm_i = s >>> 20;
        imm_s = ((s >>> 25) * 32) + int'(w[11:7]);
        imm_b = ((s >>> 31) * 4096) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        imm_j = ((s >>> 31) * 1048576) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        e = '{default: '0};
        legal = 1'b0; writes = 1'b0; no_rd = 1'b0; c = CLS_ILLEGAL;
        case (op)
            'h33: begin c = CLS_R; writes = 1; legal = (f7 == 0) || (f7 == 32 && f3 inside {0, 5}); end
            'h13: begin
                c = CLS_I; writes = 1; e.imm = imm_i;
                legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 inside {0, 32}) : 1'b1;
            end
            'h03: begin c = CLS_LOAD; writes = 1; e.imm = imm_i; legal = !(f3 inside {3, 6, 7}); end
            'h23: begin c = CLS_STORE; no_rd = 1; e.imm = imm_s; legal = (f3 <= 2); end
            'h63: begin c = CLS_BRANCH; no_rd = 1; e.imm = imm_b; legal = !(f3 inside {2, 3}); end
            'h6F: begin c = CLS_JAL; writes = 1; e.imm = imm_j; legal = 1; end
            'h67: begin c = CLS_JALR; writes = 1; e.imm = imm_i; legal = (f3 == 0); end
            'h37: begin c = CLS_LUI; writes = 1; e.imm = w & 32'hFFFFF000; legal = 1; end
            'h17: begin c = CLS_AUIPC; writes = 1; e.imm = w & 32'hFFFFF000; legal = 1; end
            'h0F: begin c = CLS_FENCE; no_rd = 1; e.imm = imm_i; legal = (f3 == 0) || (f3 == 1 && en_fencei); end
            'h73: begin
                if (f3 == 0) begin
                    c = CLS_SYSTEM; no_rd = 1; e.imm = imm_i;
                    legal = (int'(w[31:20]) inside {0, 1}) && (rdn == 0) && (w[19:15] == 5'd0);
                end else begin
                    c = CLS_CSR; writes = 1;
                    e.imm = (f3 >= 4) ? 32'(int'(w[19:15])) : imm_i;
                    legal = (f3 != 4) && en_csr;
                end
            end
            default: legal = 1'b0;
        endcase
        e.cls     = legal ? c : CLS_ILLEGAL;
        e.illegal = !legal;
        e.funct3  = w[14:12];
        e.alt     = w[30];
        e.rd      = no_rd ? 5'd0 : w[11:7];
        e.rs1     = w[19:15];
        e.rs2     = w[24:20];
        e.csr     = w[31:20];
        e.rd_we   = writes && legal && (rdn != 0);
        return e;
    endfunction

    function automatic obs_t captureFull();
        return '{f_in_ready, f_out_valid, f_pc, f_class, f_funct3, f_alt, f_rd, f_rs1, f_rs2,
                 f_imm, f_csr, f_rd_we, f_illegal};
    endfunction

    function automatic obs_t captureMin();
        return '{m_in_ready, m_out_valid, m_pc, m_class, m_funct3, m_alt, m_rd, m_rs1, m_rs2,
                 m_imm, m_csr, m_rd_we, m_illegal};
    endfunction

    task automatic checkDut(input string tag, input obs_t o, input bit en_csr, input bit en_fencei);
        exp_t e;
        cmp({tag, ".in_ready"}, 32'(o.in_ready), 32'(model_ready));
        cmp({tag, ".out_valid"}, 32'(o.out_valid), 32'(sb.size() > 0));
        if (sb.size() > 0) begin
            e = refDecode(sb[0].instr, en_csr, en_fencei);
            cmp({tag, ".pc"}, 32'(o.pc), 32'(sb[0].pc));
            cmp({tag, ".class"}, 32'(o.cls), 32'(e.cls));
            cmp({tag, ".illegal"}, 32'(o.illegal), 32'(e.illegal));
            cmp({tag, ".rd_we"}, 32'(o.rd_we), 32'(e.rd_we));
            if (!e.illegal) begin
                cmp({tag, ".fields"}, {11'd0, o.funct3, o.alt, o.rd, o.rs1, o.rs2, 2'd0},
                    {11'd0, e.funct3, e.alt, e.rd, e.rs1, e.rs2, 2'd0});
                cmp({tag, ".imm"}, o.imm, e.imm);
                cmp({tag, ".csr"}, 32'(o.csr), 32'(e.csr));
            end
        end else if (was_reset) begin
            cmp({tag, ".rst_pc"}, 32'(o.pc), 32'd0);
            cmp({tag, ".rst_class"}, 32'(o.cls), 32'd0);
            cmp({tag, ".rst_imm"}, o.imm, 32'd0);
            cmp({tag, ".rst_fields"}, {o.funct3, o.alt, o.rd, o.rs1, o.rs2, o.csr, o.rd_we, o.illegal}, 32'd0);
        end
    endtask

    task automatic checkOutput();
        checkDut("full", captureFull(), 1'b1, 1'b1);
        checkDut("min", captureMin(), 1'b0, 1'b0);
    endtask

    // Drives one cycle of inputs, advances the reference model across the edge, then checks.
    task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                 input logic [11:0] pc, input logic [31:0] ins, input logic ordy);
        rst = r; flush = f; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
        last_accepted = 1'b0;
        if (!r && f_out_valid === 1'b1 && ordy) delivered.push_back(f_pc);
        @(posedge clk);
        if (r) begin
            sb.delete(); model_ready = 1'b0; was_reset = 1'b1;
        end else if (f) begin
            sb.delete(); model_ready = 1'b1; was_reset = 1'b0;
        end else begin
            if (sb.size() > 0 && ordy) void'(sb.pop_front());
            if (iv && model_ready) begin
                sb.push_back('{pc, ins});
                last_accepted = 1'b1;
            end
            model_ready = (sb.size() < 2);
            was_reset = 1'b0;
        end
        #1;
        checkOutput();
    endtask

    function automatic logic [31:0] randInstr();
        logic [6:0]  ops[11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 10)];
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    initial begin
        logic [11:0] rpc;
        logic [31:0] rins;
        bit          have;
        bit          riv;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_instr = '0;

        // Reset state, then in_ready rises on the first cycle out of reset.
        applyStimulus(1, 0, 0, 12'h000, 32'h0, 0);
        applyStimulus(1, 0, 0, 12'h000, 32'h0, 0);
        cmp("rst.in_ready", 32'(f_in_ready), 32'd0);
        applyStimulus(0, 0, 0, 12'h000, 32'h0, 1);
        cmp("post_rst.in_ready", 32'(f_in_ready), 32'd1);

        // addi x1,x0,5
        applyStimulus(0, 0, 1, 12'h004, 32'h00500093, 1);
        cmp("addi.valid", 32'(f_out_valid), 32'd1);
        cmp("addi.class", 32'(f_class), 32'(CLS_I));
        cmp("addi.rd", 32'(f_rd), 32'd1);
        cmp("addi.rs1", 32'(f_rs1), 32'd0);
        cmp("addi.imm", f_imm, 32'h00000005);
        cmp("addi.rd_we", 32'(f_rd_we), 32'd1);
        cmp("addi.illegal", 32'(f_illegal), 32'd0);

        // beq x0,x0,-4
        applyStimulus(0, 0, 1, 12'h008, 32'hFE000EE3, 1);
        cmp("beq.class", 32'(f_class), 32'(CLS_BRANCH));
        cmp("beq.imm", f_imm, 32'hFFFFFFFC);
        cmp("beq.rd", 32'(f_rd), 32'd0);
        cmp("beq.rd_we", 32'(f_rd_we), 32'd0);
        applyStimulus(0, 0, 0, 12'h000, 32'h0, 1);

        // Back-pressure: three beats with execute stalled, then drain in order.
        delivered.delete();
        applyStimulus(0, 0, 1, 12'h100, 32'h002081B3, 0);
        applyStimulus(0, 0, 1, 12'h104, 32'h40208233, 0);
        cmp("bp.in_ready_low", 32'(f_in_ready), 32'd0);
        applyStimulus(0, 0, 1, 12'h108, 32'h123452B7, 0);
        cmp("bp.hold_pc", 32'(f_pc), 32'h100);
        applyStimulus(0, 0, 1, 12'h108, 32'h123452B7, 1);
        applyStimulus(0, 0, 1, 12'h108, 32'h123452B7, 1);
        applyStimulus(0, 0, 0, 12'h000, 32'h0, 1);
        applyStimulus(0, 0, 0, 12'h000, 32'h0, 1);
        cmp("bp.count", 32'(delivered.size()), 32'd3);
        if (delivered.size() == 3) begin
            cmp("bp.order0", 32'(delivered[0]), 32'h100);
            cmp("bp.order1", 32'(delivered[1]), 32'h104);
            cmp("bp.order2", 32'(delivered[2]), 32'h108);
        end

        // Illegal and configuration-dependent encodings.
        applyStimulus(0, 0, 1, 12'h200, 32'h00000000, 1);
        cmp("zero.illegal", 32'(f_illegal), 32'd1);
        cmp("zero.rd_we", 32'(f_rd_we), 32'd0);
        applyStimulus(0, 0, 1, 12'h204, 32'h0000300F, 1);
        cmp("fence3.illegal", 32'(f_illegal), 32'd1);
        applyStimulus(0, 0, 1, 12'h208, 32'h0000100F, 1);
        cmp("fencei.full_class", 32'(f_class), 32'(CLS_FENCE));
        cmp("fencei.min_illegal", 32'(m_illegal), 32'd1);
        applyStimulus(0, 0, 1, 12'h20C, 32'h30002573, 1);
        cmp("csrrs.full_class", 32'(f_class), 32'(CLS_CSR));
        cmp("csrrs.min_illegal", 32'(m_illegal), 32'd1);
        applyStimulus(0, 0, 1, 12'h210, 32'h00000073, 1);
        cmp("ecall.class", 32'(m_class), 32'(CLS_SYSTEM));
        applyStimulus(0, 0, 0, 12'h000, 32'h0, 1);

        // Flush with the skid full and a beat offered.
        applyStimulus(0, 0, 1, 12'h300, 32'h00100113, 0);
        applyStimulus(0, 0, 1, 12'h304, 32'h00200193, 0);
        applyStimulus(0, 1, 1, 12'h308, 32'h00300213, 0);
        cmp("flush.out_valid", 32'(f_out_valid), 32'd0);
        cmp("flush.in_ready", 32'(f_in_ready), 32'd1);
        applyStimulus(0, 0, 0, 12'h000, 32'h0, 1);
        // Flush in a cycle where a beat is accepted: that beat is dropped too.
        applyStimulus(0, 0, 1, 12'h310, 32'h00400293, 0);
        applyStimulus(0, 1, 1, 12'h314, 32'h00500313, 0);
        applyStimulus(0, 0, 0, 12'h000, 32'h0, 1);
        cmp("flush2.out_valid", 32'(f_out_valid), 32'd0);

        // Reset mid-stream with the skid full.
        applyStimulus(0, 0, 1, 12'h400, 32'h00600393, 0);
        applyStimulus(0, 0, 1, 12'h404, 32'h00700413, 0);
        applyStimulus(1, 0, 1, 12'h408, 32'h00800493, 0);
        cmp("midrst.out_valid", 32'(f_out_valid), 32'd0);
        applyStimulus(0, 0, 0, 12'h000, 32'h0, 1);
        applyStimulus(0, 0, 1, 12'h40C, 32'h00900513, 1);
        cmp("midrst.next_pc", 32'(f_pc), 32'h40C);

        // Randomized traffic against the reference model.
        have = 1'b0; rpc = '0; rins = '0;
        for (int n = 0; n < 600; n++) begin
            if (!have) begin
                rins = randInstr();
                rpc  = 12'($urandom);
                have = 1'b1;
            end
            riv = ($urandom_range(0, 9) < 7);
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 3), riv,
                          rpc, rins, ($urandom_range(0, 9) < 6));
            if (last_accepted) have = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
